// File: rtl/systolic_seq_pkg.sv
// Shared types for the systolic run sequencer: FSM state encoding and error codes.
package systolic_seq_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START,
        WAIT_HI,
        WAIT_LO,
        GAP,
        CLEAR,
        GAP2,
        DONE,
        ERR
    } seq_state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_ACK  = 2'd1;
    localparam logic [1:0] ERR_RUN  = 2'd2;

    // States in which a new job command may be accepted.
    function automatic logic is_ready_state(input seq_state_t s);
        return (s == IDLE) || (s == DONE) || (s == ERR);
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter that stops at zero; zero_o is high while the count is zero.
module seq_timer #(
    parameter int TMO_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [TMO_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [TMO_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TMO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/systolic_run_sequencer.sv
// Start/busy/clear_all initiator for the systolic array: issues runs, gaps and clears, flags timeouts.
// Optional busy-cycle performance counter (output busy_cycles) is built when SEQ_PERF_CNT_EN is defined.
module systolic_run_sequencer
    import systolic_seq_pkg::*;
#(
    parameter int RUN_CNT_W   = 8,
    parameter int TMO_W       = 16,
    parameter int ACK_TIMEOUT = 16,
    parameter int RUN_TIMEOUT = 1000,
    parameter int GAP_CYCLES  = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [RUN_CNT_W-1:0] cmd_runs,
    input  logic                 cmd_clr,
    input  logic                 abort,
    output logic                 start,
    output logic                 clear_all,
    input  logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [1:0]           err_code,
    output logic [RUN_CNT_W-1:0] run_count
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0]          busy_cycles
`endif
);

    // Timer loads are one/two short because the loading cycle and the cycle in which
    // busy is first seen low already count towards the window.
    localparam logic             GAP_SKIP = (GAP_CYCLES < 2);
    localparam logic [TMO_W-1:0] ACK_LOAD = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] RUN_LOAD = TMO_W'(RUN_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] GAP_LOAD = GAP_SKIP ? '0 : TMO_W'(GAP_CYCLES - 2);

    seq_state_t           state_q, state_d;
    logic [RUN_CNT_W-1:0] runs_q, runs_d;
    logic                 clr_q, clr_d;
    logic [RUN_CNT_W-1:0] run_count_q, run_count_d;
    logic [1:0]           err_code_q, err_code_d;
    logic                 start_q, start_d;
    logic                 clear_q, clear_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    logic                 ready_q, ready_d;
    logic                 accept;
    logic                 tmr_load;
    logic [TMO_W-1:0]     tmr_val;
    logic                 tmr_zero;

    seq_timer #(.TMO_W(TMO_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    // Handshake: a command transfers on a cycle where cmd_valid && cmd_ready, unless abort is high.
    assign accept = cmd_valid && ready_q && !abort;

    always_comb begin
        state_d     = state_q;
        runs_d      = runs_q;
        clr_d       = clr_q;
        run_count_d = run_count_q;
        err_code_d  = err_code_q;
        start_d     = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = '0;

        if (abort) begin
            state_d    = IDLE;
            err_code_d = ERR_NONE;
        end else begin
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (accept) begin
                        runs_d      = cmd_runs;
                        clr_d       = cmd_clr;
                        run_count_d = '0;
                        err_code_d  = ERR_NONE;
                        state_d     = (cmd_runs == '0) ? DONE : START;
                    end
                end
                START: begin
                    if (!busy) begin
                        start_d  = 1'b1;
                        tmr_load = 1'b1;
                        tmr_val  = ACK_LOAD;
                        state_d  = WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (busy) begin
                        tmr_load = 1'b1;
                        tmr_val  = RUN_LOAD;
                        state_d  = WAIT_LO;
                    end else if (tmr_zero) begin
                        err_code_d = ERR_ACK;
                        state_d    = ERR;
                    end
                end
                WAIT_LO: begin
                    if (!busy) begin
                        run_count_d = run_count_q + RUN_CNT_W'(1);
                        if (run_count_d == runs_q) begin
                            state_d = DONE;
                        end else if (GAP_SKIP) begin
                            state_d = clr_q ? CLEAR : START;
                        end else begin
                            tmr_load = 1'b1;
                            tmr_val  = GAP_LOAD;
                            state_d  = GAP;
                        end
                    end else if (tmr_zero) begin
                        err_code_d = ERR_RUN;
                        state_d    = ERR;
                    end
                end
                GAP: begin
                    if (tmr_zero) begin
                        state_d = clr_q ? CLEAR : START;
                    end
                end
                CLEAR: begin
                    if (GAP_SKIP) begin
                        state_d = START;
                    end else begin
                        tmr_load = 1'b1;
                        tmr_val  = GAP_LOAD;
                        state_d  = GAP2;
                    end
                end
                GAP2: begin
                    if (tmr_zero) begin
                        state_d = START;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        clear_d = (state_d == CLEAR);
        // A zero-run job accepted while already in DONE must still pulse done.
        done_d  = (state_d == DONE) && ((state_q != DONE) || accept);
        error_d = (state_d == ERR);
        ready_d = is_ready_state(state_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            runs_q      <= '0;
            clr_q       <= 1'b0;
            run_count_q <= '0;
            err_code_q  <= ERR_NONE;
            start_q     <= 1'b0;
            clear_q     <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            runs_q      <= runs_d;
            clr_q       <= clr_d;
            run_count_q <= run_count_d;
            err_code_q  <= err_code_d;
            start_q     <= start_d;
            clear_q     <= clear_d;
            done_q      <= done_d;
            error_q     <= error_d;
            ready_q     <= ready_d;
        end
    end

    assign cmd_ready = ready_q;
    assign start     = start_q;
    assign clear_all = clear_q;
    assign done      = done_q;
    assign error     = error_q;
    assign err_code  = err_code_q;
    assign run_count = run_count_q;

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] busy_cycles_q, busy_cycles_d;

    always_comb begin
        busy_cycles_d = busy_cycles_q;
        if (accept) begin
            busy_cycles_d = '0;
        end else if (busy && ((state_q == WAIT_HI) || (state_q == WAIT_LO))
                     && (busy_cycles_q != '1)) begin
            busy_cycles_d = busy_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cycles_q <= '0;
        end else begin
            busy_cycles_q <= busy_cycles_d;
        end
    end

    assign busy_cycles = busy_cycles_q;
`endif

endmodule

// File: tb/tb_systolic_run_sequencer.sv
// Directed bench for systolic_run_sequencer: array busy model, event-timeline scoreboard, timeout and abort cases.
module tb_systolic_run_sequencer;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_runs;
    logic       cmd_clr;
    logic       abort;
    logic       start;
    logic       clear_all;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] err_code;
    logic [7:0] run_count;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] busy_cycles;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_len = 20;
    int busy_left = 0;
    logic start_prev = 1'b0;

    // Event timeline: {cycle since accept, code}; code 1 start, 2 clear_all, 3 done.
    logic [17:0] exp_q[$];
    logic [17:0] obs_q[$];

    systolic_run_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_runs  (cmd_runs),
        .cmd_clr   (cmd_clr),
        .abort     (abort),
        .start     (start),
        .clear_all (clear_all),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_code  (err_code),
        .run_count (run_count)
`ifdef SEQ_PERF_CNT_EN
        ,
        .busy_cycles (busy_cycles)
`endif
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs after the edge, log events, advance the array model.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (start_prev && busy_len > 0) busy_left = busy_len;
        if (busy_left > 0) begin
            busy = 1'b1;
            busy_left--;
        end else begin
            busy = 1'b0;
        end
        start_prev = start;
        if (start)     obs_q.push_back({cyc[15:0], 2'd1});
        if (clear_all) obs_q.push_back({cyc[15:0], 2'd2});
        if (done)      obs_q.push_back({cyc[15:0], 2'd3});
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    // Presents a command for one cycle; the accepting edge becomes cycle 0.
    task automatic send_cmd(input logic [7:0] runs, input logic clr);
        cmd_valid = 1'b1;
        cmd_runs  = runs;
        cmd_clr   = clr;
        cyc       = -1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic expect_ev(input int at, input logic [1:0] code);
        exp_q.push_back({at[15:0], code});
    endtask

    task automatic compare_events(input string tag);
        logic [17:0] e;
        logic [17:0] o;
        chk({tag, "_ev_count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            chk({tag, "_ev"}, o, e);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_runs  = '0;
        cmd_clr   = 1'b0;
        abort     = 1'b0;
        busy      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outputs", {cmd_ready, start, clear_all, done, error, err_code, run_count},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0});
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", cmd_ready, 1'b1);

        // Two runs, no clears: start@1, busy 2..21, gap, start@33, done@55.
        busy_len = 20;
        send_cmd(8'd2, 1'b0);
        chk("t1_ready_low", cmd_ready, 1'b0);
        run_to(60);
        expect_ev(1, 2'd1);
        expect_ev(33, 2'd1);
        expect_ev(55, 2'd3);
        compare_events("t1");
        chk("t1_run_count", run_count, 8'd2);
        chk("t1_ready_back", cmd_ready, 1'b1);

        // Three runs with clears: clear_all 10 cycles after busy is first low (22->32, 64->74).
        send_cmd(8'd3, 1'b1);
        run_to(115);
        expect_ev(1, 2'd1);
        expect_ev(32, 2'd2);
        expect_ev(43, 2'd1);
        expect_ev(74, 2'd2);
        expect_ev(85, 2'd1);
        expect_ev(107, 2'd3);
        compare_events("t2");
        chk("t2_run_count", run_count, 8'd3);

        // Busy never rises: ack timeout 16 cycles after the start pulse.
        busy_len = 0;
        send_cmd(8'd1, 1'b0);
        run_to(16);
        chk("t3_err_not_yet", error, 1'b0);
        tick();
        chk("t3_error", {error, err_code}, {1'b1, 2'd1});
        chk("t3_ready_in_err", cmd_ready, 1'b1);
        run_to(25);
        chk("t3_error_sticky", error, 1'b1);
        expect_ev(1, 2'd1);
        compare_events("t3");

        // Abort out of ERR clears the error.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_err_clear", {error, err_code, cmd_ready}, {1'b0, 2'd0, 1'b1});

        // Busy stuck high: WAIT_LO from cycle 3, run timeout shows at cycle 1003.
        busy_len = 1200;
        send_cmd(8'd1, 1'b0);
        run_to(1002);
        chk("t4_err_not_yet", error, 1'b0);
        tick();
        chk("t4_error", {error, err_code}, {1'b1, 2'd2});
        run_to(1210);
        expect_ev(1, 2'd1);
        compare_events("t4");

        // Zero-run job from ERR: done next cycle, no start, error cleared.
        send_cmd(8'd0, 1'b0);
        chk("t5_done", {done, error, err_code, run_count}, {1'b1, 1'b0, 2'd0, 8'd0});
        tick();
        chk("t5_done_pulse", done, 1'b0);
        run_to(10);
        expect_ev(0, 2'd3);
        compare_events("t5");

        // Abort while in WAIT_LO.
        busy_len = 20;
        send_cmd(8'd2, 1'b0);
        run_to(10);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t6_abort_idle", {cmd_ready, start, clear_all, done, error}, {1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        run_to(60);
        expect_ev(1, 2'd1);
        compare_events("t6");

        // Abort and cmd_valid together: command is dropped.
        cmd_valid = 1'b1;
        cmd_runs  = 8'd0;
        abort     = 1'b1;
        tick();
        cmd_valid = 1'b0;
        abort     = 1'b0;
        chk("t7_abort_wins", {done, cmd_ready}, {1'b0, 1'b1});
        repeat (3) tick();
        chk("t7_no_late_done", obs_q.size(), 0);

        // Reset asserted while clear_all is high: outputs drop immediately.
        send_cmd(8'd3, 1'b1);
        run_to(32);
        chk("t8_clear_seen", clear_all, 1'b1);
        rst_n      = 1'b0;
        busy_left  = 0;
        busy       = 1'b0;
        start_prev = 1'b0;
        #1;
        chk("t8_rst_drop", {start, clear_all, cmd_ready, done}, {1'b0, 1'b0, 1'b1, 1'b0});
        repeat (3) tick();
        rst_n = 1'b1;
        run_to(60);
        expect_ev(1, 2'd1);
        expect_ev(32, 2'd2);
        compare_events("t8");
        chk("t8_idle_after", {cmd_ready, error, run_count}, {1'b1, 1'b0, 8'd0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
